intra_filter_acc: RTL and testbench

//  Downstream of the MCM constant-multiplier stage in the angular prediction datapath.

---
 rtl/intra_filter_acc.sv | 134 +++++++++++++
 tb/tb_intra_filter_acc.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/intra_filter_acc.sv
// Signed 4-tap accumulate, round, shift and clip stage of the angular intra predictor.
// Optional clipped-sample counter on port clip_cnt, enabled by `INTRA_ACC_CLIP_STATS_EN.
module intra_filter_acc #(
    parameter int IN_W          = 16,
    parameter int BIT_DEPTH     = 8,
    parameter int SHIFT         = 6,
    parameter int BLOCK_SAMPLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      tap0,
    input  logic [IN_W-1:0]      tap1,
    input  logic [IN_W-1:0]      tap2,
    input  logic [IN_W-1:0]      tap3,
    input  logic [3:0]           tap_neg,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_DEPTH-1:0] out_sample,
    output logic                 out_last
`ifdef INTRA_ACC_CLIP_STATS_EN
    ,
    output logic [15:0]          clip_cnt
`endif
);

    localparam int SW = IN_W + 3;
    localparam int RW = IN_W + 4;
    localparam int CW = (BLOCK_SAMPLES > 1) ? $clog2(BLOCK_SAMPLES) : 1;
    localparam logic [CW-1:0]        CNT_MAX = CW'(BLOCK_SAMPLES - 1);
    localparam logic signed [RW-1:0] MAXV    = RW'((1 << BIT_DEPTH) - 1);
    localparam logic signed [RW-1:0] RND     = RW'(1 << (SHIFT - 1));

    logic                 run;
    logic                 s1_valid;
    logic signed [SW-1:0] s1_sum;
    logic signed [SW-1:0] sum_c;
    logic signed [RW-1:0] rnd_c;
    logic signed [RW-1:0] r_c;
    logic [BIT_DEPTH-1:0] sat_c;
    logic                 clip_c;
    logic                 out_clip;
    logic                 s1_en;
    logic                 s2_en;
    logic                 xfer;
    logic [CW-1:0]        cnt;
    logic [IN_W-1:0]      taps [4];

    assign taps[0] = tap0;
    assign taps[1] = tap1;
    assign taps[2] = tap2;
    assign taps[3] = tap3;

    // in_ready is held low through the first cycle after reset via run.
    always_comb begin
        s2_en    = !out_valid || out_ready;
        s1_en    = !s1_valid || s2_en;
        in_ready = s1_en && run;
        xfer     = out_valid && out_ready;
        out_last = out_valid && (cnt == CNT_MAX);
    end

    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (tap_neg[i])
                sum_c = sum_c - $signed({3'b000, taps[i]});
            else
                sum_c = sum_c + $signed({3'b000, taps[i]});
        end
    end

    // One extra bit of headroom: the rounding add can carry past the IN_W+3 sum range.
    always_comb begin
        rnd_c  = RW'(s1_sum) + RND;
        r_c    = rnd_c >>> SHIFT;
        sat_c  = r_c[BIT_DEPTH-1:0];
        clip_c = 1'b0;
        if (r_c[RW-1]) begin
            sat_c  = '0;
            clip_c = 1'b1;
        end else if (r_c > MAXV) begin
            sat_c  = '1;
            clip_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run      <= 1'b0;
            s1_valid <= 1'b0;
            s1_sum   <= '0;
        end else begin
            run <= 1'b1;
            if (s1_en) begin
                s1_valid <= in_valid && run;
                s1_sum   <= sum_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_sample <= '0;
            out_clip   <= 1'b0;
        end else if (s2_en) begin
            out_valid  <= s1_valid;
            out_sample <= sat_c;
            out_clip   <= clip_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (xfer)
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    end

`ifdef INTRA_ACC_CLIP_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            clip_cnt <= '0;
        else if (xfer && out_clip && (clip_cnt != 16'hFFFF))
            clip_cnt <= clip_cnt + 16'd1;
    end
`else
    logic unused_clip;
    assign unused_clip = out_clip;
`endif

endmodule

// File: tb/tb_intra_filter_acc.sv
// Directed self-checking bench for intra_filter_acc with a queue scoreboard.
// Build with +define+INTRA_ACC_CLIP_STATS_EN to also cover clip_cnt.
module tb_intra_filter_acc;

    localparam int BS = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] tap0 = '0, tap1 = '0, tap2 = '0, tap3 = '0;
    logic [3:0]  tap_neg = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_sample;
    logic        out_last;
`ifdef INTRA_ACC_CLIP_STATS_EN
    logic [15:0] clip_cnt;
`endif

    intra_filter_acc #(
        .IN_W(16), .BIT_DEPTH(8), .SHIFT(6), .BLOCK_SAMPLES(BS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .tap0(tap0), .tap1(tap1), .tap2(tap2), .tap3(tap3), .tap_neg(tap_neg),
        .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample),
        .out_last(out_last)
`ifdef INTRA_ACC_CLIP_STATS_EN
        , .clip_cnt(clip_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] t0, t1, t2, t3;
        logic [3:0]  neg;
        logic [7:0]  exp;
    } stim_t;

    stim_t stim_q[$];
    int    exp_q[$];
    int    acc_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    xfer = 0;
    int    lasts = 0;
    int    mode = 0;   // 0: out_ready=1, 1: random, 2: out_ready=0
    bit    stall_prev = 0;
    logic [7:0] prev_sample = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model(input int t0, t1, t2, t3, input logic [3:0] neg);
        int s, r;
        s = (neg[0] ? -t0 : t0) + (neg[1] ? -t1 : t1) + (neg[2] ? -t2 : t2) + (neg[3] ? -t3 : t3);
        r = (s + 32) >>> 6;
        if (r < 0) return 0;
        if (r > 255) return 255;
        return r;
    endfunction

    task automatic send(input int t0, t1, t2, t3, input logic [3:0] neg, input int exp);
        stim_t s;
        s.t0 = 16'(t0); s.t1 = 16'(t1); s.t2 = 16'(t2); s.t3 = 16'(t3);
        s.neg = neg; s.exp = 8'(exp);
        stim_q.push_back(s);
    endtask

    task automatic send_model(input int t0, t1, t2, t3, input logic [3:0] neg);
        send(t0, t1, t2, t3, neg, model(t0, t1, t2, t3, neg));
    endtask

    // One clock: drive at negedge, observe handshakes 1 ns later, then let the edge happen.
    task automatic step();
        int e;
        @(negedge clk);
        if (stim_q.size() > 0) begin
            in_valid = 1'b1;
            tap0 = stim_q[0].t0; tap1 = stim_q[0].t1;
            tap2 = stim_q[0].t2; tap3 = stim_q[0].t3;
            tap_neg = stim_q[0].neg;
        end else begin
            in_valid = 1'b0;
            tap0 = 16'hDEAD; tap1 = 16'hBEEF; tap2 = '0; tap3 = '0; tap_neg = 4'hF;
        end
        out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
        if (stall_prev) begin
            check("stall_valid", out_valid, 1);
            check("stall_sample", out_sample, prev_sample);
        end
        if (out_valid && !out_ready && exp_q.size() == 2)
            check("in_ready_full", in_ready, 0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("sample", out_sample, e);
                check("last", out_last, ((xfer % BS) == BS - 1) ? 1 : 0);
                if (mode == 0) check("latency", cyc - acc_q[0], 2);
                void'(acc_q.pop_front());
                if (out_last) lasts++;
                xfer++;
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(int'(stim_q[0].exp));
            acc_q.push_back(cyc);
            void'(stim_q.pop_front());
        end
        stall_prev  = out_valid && !out_ready;
        prev_sample = out_sample;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((stim_q.size() > 0 || exp_q.size() > 0) && n < maxc) begin
            step();
            n++;
        end
        check("drain_timeout", stim_q.size() + exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_sample", out_sample, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stim_q.delete(); exp_q.delete(); acc_q.delete();
        xfer = 0; stall_prev = 0;
    endtask

    initial begin
        do_reset();
`ifdef INTRA_ACC_CLIP_STATS_EN
        check("rst_clip_cnt", clip_cnt, 0);
`endif

        // Basic, signed-tap and clipping vectors, one at a time with latency checks.
        mode = 0;
        send(6400, 0, 0, 0, 4'b0000, 100);      drain(20);
        send(0, 6400, 20, 100, 4'b1001, 99);    drain(20);
        send(19200, 0, 0, 0, 4'b0000, 255);     drain(20);
        send(0, 0, 0, 640, 4'b1000, 0);         drain(20);
`ifdef INTRA_ACC_CLIP_STATS_EN
        check("clip_cnt_two", clip_cnt, 2);
`endif
        // Clip boundaries and extreme tap sums, back to back.
        send(16288, 0, 0, 0, 4'b0000, 255);
        send(16352, 0, 0, 0, 4'b0000, 255);
        send(32, 0, 0, 0, 4'b0001, 0);
        send(33, 0, 0, 0, 4'b0001, 0);
        send(65535, 65535, 65535, 65535, 4'b0000, 255);
        send(65535, 65535, 65535, 65535, 4'b1111, 0);
        send(0, 3200, 0, 64, 4'b0000, 51);
        drain(40);

        // Random backpressure over 8 sets.
        mode = 1;
        for (int i = 0; i < 8; i++)
            send_model($urandom_range(0, 20000), $urandom_range(0, 8000),
                       $urandom_range(0, 8000), $urandom_range(0, 4000), 4'($urandom_range(0, 15)));
        drain(200);

        // 40-sample stream from a fresh block boundary.
        do_reset();
        mode = 0; lasts = 0;
        for (int i = 0; i < 40; i++)
            send_model(i * 64, 16, 0, 0, 4'b0000);
        drain(100);
        check("lasts_in_40", lasts, 2);

        // Reset with two samples in flight, then one full block.
        mode = 2;
        send(6400, 0, 0, 0, 4'b0000, 100);
        send(6464, 0, 0, 0, 4'b0000, 101);
        send(6528, 0, 0, 0, 4'b0000, 102);
        repeat (3) step();
        check("inflight_two", exp_q.size(), 2);
        do_reset();
        mode = 0; lasts = 0;
        for (int i = 0; i < BS; i++)
            send(i * 64 + 640, 0, 0, 0, 4'b0000, i + 10);
        drain(60);
        check("lasts_after_reset", lasts, 1);

        step();
        check("idle_out_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
